// File: rtl/sw_debounce_sync.sv
// Switch/pushbutton conditioner: per-channel synchroniser, debounce FSM,
// clean level plus one-cycle rise/fall strobes for the switch PIO.
module sw_debounce_sync #(
  parameter int WIDTH = 3,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] settling
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit IMMEDIATE = (DEBOUNCE_CYCLES == 1);

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= RESET_VALUE;
    end else begin
      sync_q[0] <= sw_raw;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          accept;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
        STABLE: begin
          if (s[g] == clean_q) begin
            cnt_d = '0;
          end else if (IMMEDIATE) begin
            accept = 1'b1;
          end else begin
            state_d = SETTLE;
            cnt_d   = CW'(1);
          end
        end
        SETTLE: begin
          // Any return to the old level is a glitch; restart from zero
          if (s[g] == clean_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            accept = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
      if (accept) begin
        state_d = STABLE;
        cnt_d   = '0;
      end
      clean_d = accept ? s[g] : clean_q;
      rise_d  = accept & s[g];
      fall_d  = accept & ~s[g];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= STABLE;
        cnt_q   <= '0;
        clean_q <= RESET_VALUE[g];
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        clean_q <= clean_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign sw_clean[g] = clean_q;
    assign sw_rise[g]  = rise_q;
    assign sw_fall[g]  = fall_q;
    assign settling[g] = (state_q == SETTLE);
  end

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Self-checking bench for sw_debounce_sync: directed scenarios plus
// randomized bouncing checked against a run-length reference model.
module tb_sw_debounce_sync;

  localparam int W  = 3;
  localparam int SS = 2;
  localparam int D  = 4;
  localparam logic [W-1:0] RV = 3'b000;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean, sw_rise, sw_fall, settling;

  int n_tests = 0;
  int n_fail  = 0;

  sw_debounce_sync #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(D),
    .RESET_VALUE(RV)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sw_raw(sw_raw),
    .sw_clean(sw_clean),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .settling(settling)
  );

  always #5 clk = ~clk;

  // Reference: pin delayed SS edges, then a level is accepted once it has
  // disagreed with the clean level for D consecutive samples.
  logic [W-1:0] m_pipe [SS];
  logic [W-1:0] m_clean, m_rise, m_fall;
  int           m_run [W];

  always @(posedge clk or negedge reset_n) begin : model
    logic [W-1:0] sv, nc, nr, nf;
    int nrun;
    if (!reset_n) begin
      for (int i = 0; i < SS; i++) m_pipe[i] <= RV;
      for (int i = 0; i < W; i++) m_run[i] <= 0;
      m_clean <= RV;
      m_rise  <= '0;
      m_fall  <= '0;
    end else begin
      sv = m_pipe[SS-1];
      nc = m_clean;
      nr = '0;
      nf = '0;
      for (int i = 0; i < W; i++) begin
        nrun = (sv[i] != m_clean[i]) ? m_run[i] + 1 : 0;
        if (nrun == D) begin
          nc[i] = sv[i];
          nr[i] = sv[i];
          nf[i] = ~sv[i];
          nrun  = 0;
        end
        m_run[i] <= nrun;
      end
      m_clean <= nc;
      m_rise  <= nr;
      m_fall  <= nf;
      m_pipe[0] <= sw_raw;
      for (int i = 1; i < SS; i++) m_pipe[i] <= m_pipe[i-1];
    end
  end

  function automatic logic [W-1:0] m_settling();
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (m_run[i] != 0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sw_raw  = 3'b111;
    repeat (3) tick();
    n_tests++;
    if ({sw_clean, sw_rise, sw_fall, settling} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got clean=%b rise=%b fall=%b settling=%b expected all 000",
               sw_clean, sw_rise, sw_fall, settling);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      logic [W-1:0] ec, er;
      tick();
      ec = (k >= 5) ? 3'b111 : 3'b000;
      er = (k == 5) ? 3'b111 : 3'b000;
      n_tests++;
      if (sw_clean !== ec || sw_rise !== er) begin
        n_fail++;
        $display("FAIL reset_release edge%0d: got clean=%b rise=%b expected clean=%b rise=%b",
                 k, sw_clean, sw_rise, ec, er);
      end
    end
  endtask

  task automatic test_single_rise();
    sw_raw = 3'b000;
    repeat (10) tick();
    n_tests++;
    if (sw_clean !== 3'b000) begin
      n_fail++;
      $display("FAIL fall_all: got clean=%b expected 000", sw_clean);
    end
    sw_raw = 3'b001;
    for (int k = 0; k < 7; k++) begin
      logic [W-1:0] ec, er, es;
      tick();
      ec = {2'b00, 1'(k >= 5)};
      er = {2'b00, 1'(k == 5)};
      es = {2'b00, 1'(k >= 2 && k <= 4)};
      n_tests++;
      if (sw_clean !== ec || sw_rise !== er || settling !== es || sw_fall !== 3'b000) begin
        n_fail++;
        $display("FAIL bit0_rise edge%0d: got clean=%b rise=%b fall=%b settling=%b expected clean=%b rise=%b fall=000 settling=%b",
                 k, sw_clean, sw_rise, sw_fall, settling, ec, er, es);
      end
    end
  endtask

  task automatic test_glitch();
    bit saw_settle = 0;
    for (int t = 0; t < 12; t++) begin
      sw_raw = (t < 3) ? 3'b011 : 3'b001;
      tick();
      if (settling[1]) saw_settle = 1;
      n_tests++;
      if (sw_clean !== 3'b001 || (sw_rise | sw_fall) !== 3'b000) begin
        n_fail++;
        $display("FAIL glitch t%0d: got clean=%b rise=%b fall=%b expected clean=001 no strobes",
                 t, sw_clean, sw_rise, sw_fall);
      end
    end
    n_tests++;
    if (settling[1] !== 1'b0 || !saw_settle) begin
      n_fail++;
      $display("FAIL glitch_settling: got final=%b seen=%0d expected final=0 seen=1",
               settling[1], saw_settle);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] seq = 6'b101101;
    int rises = 0, falls = 0, redge = -1;
    for (int t = 0; t < 20; t++) begin
      logic b;
      b = (t < 6) ? seq[5-t] : 1'b1;
      sw_raw = {b, 2'b01};
      tick();
      if (sw_rise[2]) begin
        rises++;
        redge = t;
      end
      if (sw_fall[2]) falls++;
    end
    n_tests++;
    if (rises != 1 || redge != 10 || falls != 0 || sw_clean !== 3'b101) begin
      n_fail++;
      $display("FAIL bounce_rise: got rises=%0d at edge%0d falls=%0d clean=%b expected 1 at edge10, 0 falls, clean=101",
               rises, redge, falls, sw_clean);
    end
    rises = 0;
    falls = 0;
    sw_raw = 3'b001;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (sw_rise[2]) rises++;
      if (sw_fall[2]) falls++;
    end
    n_tests++;
    if (rises != 0 || falls != 1 || sw_clean !== 3'b001) begin
      n_fail++;
      $display("FAIL bounce_fall: got rises=%0d falls=%0d clean=%b expected 0, 1, 001",
               rises, falls, sw_clean);
    end
  endtask

  task automatic test_reset_mid_settle();
    int rises = 0;
    sw_raw = 3'b100;
    repeat (10) tick();
    sw_raw = 3'b101;
    repeat (4) tick();
    n_tests++;
    if (sw_clean !== 3'b100 || settling !== 3'b001) begin
      n_fail++;
      $display("FAIL pre_reset: got clean=%b settling=%b expected clean=100 settling=001",
               sw_clean, settling);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (sw_clean !== 3'b000 || settling !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset: got clean=%b settling=%b expected 000 000", sw_clean, settling);
    end
    repeat (2) tick();
    n_tests++;
    if ((sw_rise | sw_fall) !== 3'b000 || sw_clean !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_hold: got clean=%b rise=%b fall=%b expected 000", sw_clean, sw_rise, sw_fall);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (sw_rise !== 3'b000) rises++;
      if (k == 4 || k == 5) begin
        logic [W-1:0] ec;
        ec = (k == 5) ? 3'b101 : 3'b000;
        n_tests++;
        if (sw_clean !== ec || sw_rise !== ((k == 5) ? 3'b101 : 3'b000)) begin
          n_fail++;
          $display("FAIL post_reset edge%0d: got clean=%b rise=%b expected clean=%b",
                   k, sw_clean, sw_rise, ec);
        end
      end
    end
    n_tests++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL post_reset_strobes: got %0d rise cycles expected 1", rises);
    end
  endtask

  task automatic test_simultaneous();
    sw_raw = 3'b000;
    repeat (10) tick();
    sw_raw = 3'b101;
    for (int k = 0; k < 7; k++) begin
      logic [W-1:0] ec, er;
      tick();
      ec = (k >= 5) ? 3'b101 : 3'b000;
      er = (k == 5) ? 3'b101 : 3'b000;
      n_tests++;
      if (sw_clean !== ec || sw_rise !== er || sw_fall !== 3'b000) begin
        n_fail++;
        $display("FAIL simultaneous edge%0d: got clean=%b rise=%b fall=%b expected clean=%b rise=%b fall=000",
                 k, sw_clean, sw_rise, sw_fall, ec, er);
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int t = 0; t < 800; t++) begin
      if (hold == 0) begin
        sw_raw = sw_raw ^ W'($urandom_range(1, 7));
        hold   = $urandom_range(1, 7);
      end
      hold--;
      tick();
      n_tests++;
      if (sw_clean !== m_clean || sw_rise !== m_rise || sw_fall !== m_fall ||
          settling !== m_settling() || (sw_rise & sw_fall) !== 3'b000) begin
        n_fail++;
        $display("FAIL random t%0d: got clean=%b rise=%b fall=%b settling=%b expected clean=%b rise=%b fall=%b settling=%b",
                 t, sw_clean, sw_rise, sw_fall, settling, m_clean, m_rise, m_fall, m_settling());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_bounce();
    test_reset_mid_settle();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
